// File: rtl/fp_byte_io_ctrl_pkg.sv
// Shared definitions for the byte-serial FP add/sub front/back end.
//   - FSM state encodings (3-bit)
//   - Command byte bit positions
//   - Word/byte geometry and counter widths
//   - byte_sel(): picks the big-endian byte of a word for a given byte index
package fp_byte_io_ctrl_pkg;

  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned CNT_W          = 2;
  localparam int unsigned TO_CNT_W       = 16;

  localparam int unsigned CMD_SUB_BIT = 0;
  localparam int unsigned CMD_ACC_BIT = 1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD_A = 3'd1;
  localparam logic [2:0] ST_LOAD_B = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_SEND   = 3'd4;

  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_WORD - 1);

  // Byte index 0 is the most significant byte (big-endian wire order).
  function automatic logic [BYTE_W-1:0] byte_sel(input logic [WORD_W-1:0] w,
                                                  input logic [CNT_W-1:0]  idx);
    logic [BYTE_W-1:0] b;
    case (idx)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/fp_byte_io_ctrl.sv
// Byte-serial front/back end for the combinational fp_addsub core.
// Collects a command byte and two 32-bit operands over an 8-bit valid/ready input,
// presents them to fp_addsub, captures the result and returns it as 4 bytes
// (MSB first) over an 8-bit valid/ready output.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_data/valid/ready   input byte stream (transfer = in_valid & in_ready)
//   out_data/valid/ready  result byte stream (transfer = out_valid & out_ready)
//   fp_a, fp_b, fp_sub    registered operands/op select to fp_addsub
//   fp_result             combinational result from fp_addsub
//   busy                  high in every state except IDLE
//   timeout_err           1-cycle pulse when an operand load is aborted
module fp_byte_io_ctrl
  import fp_byte_io_ctrl_pkg::*;
#(
  parameter int unsigned LOAD_TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] fp_a,
  output logic [WORD_W-1:0] fp_b,
  output logic              fp_sub,
  input  logic [WORD_W-1:0] fp_result,
  output logic              busy,
  output logic              timeout_err
);

  localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(LOAD_TIMEOUT - 1);
  localparam bit                  TO_EN   = (LOAD_TIMEOUT != 0);

  logic [2:0]          r_state,   w_nxt_state;
  logic [WORD_W-1:0]   r_fp_a,    w_nxt_fp_a;
  logic [WORD_W-1:0]   r_fp_b,    w_nxt_fp_b;
  logic                r_fp_sub,  w_nxt_fp_sub;
  logic [WORD_W-1:0]   r_acc,     w_nxt_acc;
  logic [WORD_W-1:0]   r_res,     w_nxt_res;
  logic [CNT_W-1:0]    r_cnt,     w_nxt_cnt;
  logic [TO_CNT_W-1:0] r_to_cnt,  w_nxt_to_cnt;
  logic                r_to_err,  w_nxt_to_err;
  logic                r_in_ready,  w_nxt_in_ready;
  logic                r_out_valid, w_nxt_out_valid;
  logic [BYTE_W-1:0]   r_out_data,  w_nxt_out_data;
  logic                r_busy,      w_nxt_busy;

  logic w_in_xfer;
  logic w_out_xfer;

  assign w_in_xfer  = in_valid & r_in_ready;
  assign w_out_xfer = r_out_valid & out_ready;

  // State and datapath registers; status outputs are registered decodes of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_fp_a      <= '0;
      r_fp_b      <= '0;
      r_fp_sub    <= 1'b0;
      r_acc       <= '0;
      r_res       <= '0;
      r_cnt       <= '0;
      r_to_cnt    <= '0;
      r_to_err    <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_fp_a      <= w_nxt_fp_a;
      r_fp_b      <= w_nxt_fp_b;
      r_fp_sub    <= w_nxt_fp_sub;
      r_acc       <= w_nxt_acc;
      r_res       <= w_nxt_res;
      r_cnt       <= w_nxt_cnt;
      r_to_cnt    <= w_nxt_to_cnt;
      r_to_err    <= w_nxt_to_err;
      r_in_ready  <= w_nxt_in_ready;
      r_out_valid <= w_nxt_out_valid;
      r_out_data  <= w_nxt_out_data;
      r_busy      <= w_nxt_busy;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_fp_a   = r_fp_a;
    w_nxt_fp_b   = r_fp_b;
    w_nxt_fp_sub = r_fp_sub;
    w_nxt_acc    = r_acc;
    w_nxt_res    = r_res;
    w_nxt_cnt    = r_cnt;
    w_nxt_to_cnt = '0;
    w_nxt_to_err = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_nxt_cnt = '0;
        if (w_in_xfer) begin
          w_nxt_fp_sub = in_data[CMD_SUB_BIT];
          if (in_data[CMD_ACC_BIT]) begin
            w_nxt_fp_a  = r_acc;
            w_nxt_state = ST_LOAD_B;
          end else begin
            w_nxt_state = ST_LOAD_A;
          end
        end
      end

      ST_LOAD_A, ST_LOAD_B: begin
        if (w_in_xfer) begin
          // Shift left so the first byte received lands in bits [31:24].
          if (r_state == ST_LOAD_A) begin
            w_nxt_fp_a = {r_fp_a[WORD_W-BYTE_W-1:0], in_data};
          end else begin
            w_nxt_fp_b = {r_fp_b[WORD_W-BYTE_W-1:0], in_data};
          end
          w_nxt_cnt = r_cnt + CNT_W'(1);
          if (r_cnt == LAST_BYTE) begin
            w_nxt_state = (r_state == ST_LOAD_A) ? ST_LOAD_B : ST_EXEC;
          end
        end else if (TO_EN) begin
          // An accepted byte takes priority over expiry in the same cycle.
          if (r_to_cnt == TO_LAST) begin
            w_nxt_state  = ST_IDLE;
            w_nxt_fp_a   = '0;
            w_nxt_fp_b   = '0;
            w_nxt_cnt    = '0;
            w_nxt_to_err = 1'b1;
          end else begin
            w_nxt_to_cnt = r_to_cnt + TO_CNT_W'(1);
          end
        end
      end

      ST_EXEC: begin
        w_nxt_res   = fp_result;
        w_nxt_acc   = fp_result;
        w_nxt_cnt   = '0;
        w_nxt_state = ST_SEND;
      end

      ST_SEND: begin
        if (w_out_xfer) begin
          w_nxt_cnt = r_cnt + CNT_W'(1);
          if (r_cnt == LAST_BYTE) begin
            w_nxt_state = ST_IDLE;
          end
        end
      end

      default: begin
        w_nxt_state = ST_IDLE;
        w_nxt_cnt   = '0;
      end
    endcase
  end

  // Output decode from the next state, so outputs line up with the state they belong to.
  always_comb begin
    w_nxt_in_ready  = (w_nxt_state == ST_IDLE) || (w_nxt_state == ST_LOAD_A) ||
                      (w_nxt_state == ST_LOAD_B);
    w_nxt_out_valid = (w_nxt_state == ST_SEND);
    w_nxt_busy      = (w_nxt_state != ST_IDLE);
    w_nxt_out_data  = (w_nxt_state == ST_SEND) ? byte_sel(w_nxt_res, w_nxt_cnt) : '0;
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign fp_a        = r_fp_a;
  assign fp_b        = r_fp_b;
  assign fp_sub      = r_fp_sub;
  assign busy        = r_busy;
  assign timeout_err = r_to_err;

endmodule

// File: tb/tb_fp_byte_io_ctrl.sv
// Directed bench for fp_byte_io_ctrl with LOAD_TIMEOUT=8. fp_addsub is stood in for
// by a lookup table of hand-computed IEEE-754 results for the operand sets used here.
module tb_fp_byte_io_ctrl;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] fp_a;
  logic [31:0] fp_b;
  logic        fp_sub;
  logic [31:0] fp_result;
  logic        busy;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  fp_byte_io_ctrl #(.LOAD_TIMEOUT(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .fp_a        (fp_a),
    .fp_b        (fp_b),
    .fp_sub      (fp_sub),
    .fp_result   (fp_result),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-computed results; anything unexpected yields a quiet NaN.
  function automatic logic [31:0] fp_model(input logic [31:0] a, input logic [31:0] b,
                                           input logic s);
    if (!s && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000; // 1+2
    if ( s && a == 32'h40400000 && b == 32'h3F800000) return 32'h40000000; // 3-1
    if (!s && a == 32'h40400000 && b == 32'h3F800000) return 32'h40800000; // 3+1
    if (!s && a == 32'h00000000 && b == 32'h3F800000) return 32'h3F800000; // 0+1
    return 32'h7FC00000;
  endfunction

  always_comb fp_result = fp_model(fp_a, fp_b, fp_sub);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one byte and hold it until accepted (bounded).
  task automatic put_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_wait", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic put_word(input logic [31:0] w);
    put_byte(w[31:24]);
    put_byte(w[23:16]);
    put_byte(w[15:8]);
    put_byte(w[7:0]);
  endtask

  // Accept one output byte (bounded wait).
  task automatic get_byte(output logic [7:0] b);
    int n;
    n = 0;
    out_ready = 1'b1;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("out_valid_wait", 32'(out_valid), 32'd1);
    b = out_data;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic get_word(output logic [31:0] w);
    logic [7:0] b0, b1, b2, b3;
    get_byte(b0);
    get_byte(b1);
    get_byte(b2);
    get_byte(b3);
    w = {b0, b1, b2, b3};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] res;
    logic [7:0]  b;

    rst_n     = 1'b0;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",    32'(in_ready),    32'd1);
    check("rst_out_valid",   32'(out_valid),   32'd0);
    check("rst_out_data",    32'(out_data),    32'd0);
    check("rst_busy",        32'(busy),        32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    check("rst_fp_a",        fp_a,             32'd0);
    check("rst_fp_sub",      32'(fp_sub),      32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1.0 + 2.0, including EXEC latency
    put_byte(8'h00);
    check("t1_busy_load", 32'(busy), 32'd1);
    put_word(32'h3F800000);
    put_word(32'h40000000);
    check("t1_exec_in_ready",  32'(in_ready),  32'd0);
    check("t1_exec_out_valid", 32'(out_valid), 32'd0);
    check("t1_fp_a", fp_a, 32'h3F800000);
    check("t1_fp_b", fp_b, 32'h40000000);
    @(posedge clk); #1;
    check("t1_send_out_valid", 32'(out_valid), 32'd1);
    check("t1_send_first",     32'(out_data),  32'h40);
    check("t1_send_in_ready",  32'(in_ready),  32'd0);
    get_word(res);
    check("t1_result", res, 32'h40400000);
    check("t1_busy_after",      32'(busy),      32'd0);
    check("t1_out_valid_after", 32'(out_valid), 32'd0);
    check("t1_in_ready_after",  32'(in_ready),  32'd1);

    // ACC: 3.0 (from previous result) + 1.0
    put_byte(8'h02);
    check("t3_fp_a_acc", fp_a, 32'h40400000);
    put_word(32'h3F800000);
    get_word(res);
    check("t3_result", res, 32'h40800000);

    // 3.0 - 1.0
    put_byte(8'h01);
    check("t2_fp_sub", 32'(fp_sub), 32'd1);
    put_word(32'h40400000);
    put_word(32'h3F800000);
    get_word(res);
    check("t2_result", res, 32'h40000000);

    // Back-pressure: 3.0 + 1.0 = 40 80 00 00, stall after first byte
    put_byte(8'h00);
    put_word(32'h40400000);
    put_word(32'h3F800000);
    get_byte(b);
    check("t4_byte0", 32'(b), 32'h40);
    in_data  = 8'hFF;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("t4_hold_data",     32'(out_data),  32'h80);
      check("t4_hold_valid",    32'(out_valid), 32'd1);
      check("t4_hold_in_ready", 32'(in_ready),  32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    get_byte(b);
    check("t4_byte1", 32'(b), 32'h80);
    get_byte(b);
    check("t4_byte2", 32'(b), 32'h00);
    get_byte(b);
    check("t4_byte3", 32'(b), 32'h00);
    check("t4_busy_after", 32'(busy), 32'd0);

    // Timeout: two A bytes then 8 idle cycles
    put_byte(8'h00);
    put_byte(8'h3F);
    put_byte(8'h80);
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      check("t5_no_early_to", 32'(timeout_err), 32'd0);
      check("t5_busy_wait",   32'(busy),        32'd1);
    end
    @(posedge clk); #1;
    check("t5_to_pulse",    32'(timeout_err), 32'd1);
    check("t5_to_idle",     32'(busy),        32'd0);
    check("t5_to_in_ready", 32'(in_ready),    32'd1);
    check("t5_to_fp_a",     fp_a,             32'd0);
    @(posedge clk); #1;
    check("t5_pulse_end",   32'(timeout_err), 32'd0);
    put_byte(8'h00);
    put_word(32'h3F800000);
    put_word(32'h40000000);
    get_word(res);
    check("t5_result", res, 32'h40400000);

    // Reset during SEND, then ACC must start from zero
    put_byte(8'h00);
    put_word(32'h3F800000);
    put_word(32'h40000000);
    @(posedge clk); #1;
    check("t6_in_send", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_out_valid", 32'(out_valid), 32'd0);
    check("t6_rst_busy",      32'(busy),      32'd0);
    check("t6_rst_in_ready",  32'(in_ready),  32'd1);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    put_byte(8'h02);
    check("t6_fp_a_acc", fp_a, 32'd0);
    put_word(32'h3F800000);
    get_word(res);
    check("t6_result", res, 32'h3F800000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
